uart_rx_irr: RTL

UART_RX_IRR -- requirements
Module: uart_rx_irr

---
 rtl/lib_uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx_irr.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lib_uart_pkg.sv
// lib_uart: shared definitions for the interrupt-driven UART receiver.
//   rx_state_e            - receiver FSM state encoding
//   CLKS_PER_BIT_DEFAULT  - default bit period in clk cycles
//   DATA_BITS / STOP_BITS - 8N1 frame shape
package lib_uart;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; both flops load RST_VAL
//   d      - asynchronous input
//   q      - synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_irr.sv
// uart_rx_irr: 8N1 UART receiver with a one-byte holding register and an
// interrupt request handshake towards a CPU.
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   uart_rx   - serial line (asynchronous, idles high, LSB first)
//   ack       - interrupt acknowledge level from the CPU
//   rx_data   - last correctly framed byte
//   irr       - interrupt request, high while an unacknowledged byte is held
//   overrun   - sticky: a held byte was overwritten before acknowledge
//   frame_err - one-cycle pulse when a frame ends with a low stop bit
module uart_rx_irr
  import lib_uart::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       ack,
  output logic [7:0] rx_data,
  output logic       irr,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // The counter holds "cycles since the last event minus one", so a full bit
  // period ends at CLKS_PER_BIT-1 and always fits in clog2 bits.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_prev_q, rx_prev_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          irr_q, irr_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          stop_ok;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_prev_d   = rx_s;
    rx_data_d   = rx_data_q;
    irr_d       = irr_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    stop_ok     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a true 1->0 transition starts a frame, so a line held low
        // after a bad stop bit (break) never retriggers.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            stop_ok = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing byte takes priority over an acknowledge in the same cycle.
    // Overrun is raised only when a held byte is lost without being acked.
    if (stop_ok) begin
      rx_data_d = shift_q;
      irr_d     = 1'b1;
      overrun_d = irr_q ? ~ack : overrun_q;
    end else if (ack && irr_q) begin
      irr_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_prev_q   <= 1'b1;
      rx_data_q   <= '0;
      irr_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_prev_q   <= rx_prev_d;
      rx_data_q   <= rx_data_d;
      irr_q       <= irr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign irr       = irr_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
